// File: rtl/waveshaper_softclip.sv
// Soft-clip waveshaper control stage: launches |x|*(128+K)/(|x|+K) on an external
// sequential divider, then emits the saturated, sign-restored result.
module waveshaper_softclip #(
   parameter int KNEE    = 64,
   parameter int DIV_W   = 22,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_sample,
   output logic             in_ready,
   output logic             div_start,
   output logic [DIV_W-1:0] div_dividend,
   output logic [DIV_W-1:0] div_divisor,
   input  logic             div_done,
   input  logic [7:0]       div_quo,
   output logic             out_valid,
   output logic [7:0]       out_sample,
   output logic             timeout_err
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
   localparam logic [DIV_W-1:0] DIVIDEND_K = DIV_W'(128 + KNEE);
   localparam logic [DIV_W-1:0] DIVISOR_K  = DIV_W'(KNEE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_EMIT
   } state_t;

   state_t           state_q, state_d;
   logic             sign_q, sign_d;
   logic [DIV_W-1:0] dividend_q, dividend_d;
   logic [DIV_W-1:0] divisor_q, divisor_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       res_q, res_d;
   logic             out_valid_q, out_valid_d;
   logic [7:0]       out_sample_q, out_sample_d;
   logic             timeout_err_q, timeout_err_d;

   logic [8:0]       in_mag;
   logic [6:0]       qsat;
   logic [7:0]       shaped;

   // -128 maps to a magnitude of 128, hence the 9-bit width.
   always_comb begin
      in_mag = in_sample[7] ? (9'd256 - {1'b0, in_sample}) : {1'b0, in_sample};
      qsat   = res_q[7] ? 7'd127 : res_q[6:0];
      shaped = sign_q ? (8'd0 - {1'b0, qsat}) : {1'b0, qsat};
   end

   always_comb begin
      state_d       = state_q;
      sign_d        = sign_q;
      dividend_d    = dividend_q;
      divisor_d     = divisor_q;
      cnt_d         = cnt_q;
      res_d         = res_q;
      out_valid_d   = 1'b0;
      out_sample_d  = out_sample_q;
      timeout_err_d = timeout_err_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sign_d = in_sample[7];
               if (in_mag == 9'd0) begin
                  res_d   = 8'd0;
                  state_d = S_EMIT;
               end else begin
                  dividend_d = DIV_W'(in_mag) * DIVIDEND_K;
                  divisor_d  = DIV_W'(in_mag) + DIVISOR_K;
                  state_d    = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         // A done arriving on the final count still wins over the timeout.
         S_WAIT: begin
            if (div_done) begin
               res_d   = div_quo;
               state_d = S_EMIT;
            end else if (cnt_q == CNT_LAST) begin
               timeout_err_d = 1'b1;
               res_d         = 8'd127;
               state_d       = S_EMIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_EMIT: begin
            out_valid_d  = 1'b1;
            out_sample_d = shaped;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         sign_q        <= 1'b0;
         dividend_q    <= '0;
         divisor_q     <= '0;
         cnt_q         <= '0;
         res_q         <= 8'd0;
         out_valid_q   <= 1'b0;
         out_sample_q  <= 8'd0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sign_q        <= sign_d;
         dividend_q    <= dividend_d;
         divisor_q     <= divisor_d;
         cnt_q         <= cnt_d;
         res_q         <= res_d;
         out_valid_q   <= out_valid_d;
         out_sample_q  <= out_sample_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign in_ready     = (state_q == S_IDLE);
   assign div_start    = (state_q == S_LAUNCH);
   assign div_dividend = dividend_q;
   assign div_divisor  = divisor_q;
   assign out_valid    = out_valid_q;
   assign out_sample   = out_sample_q;
   assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_waveshaper_softclip.sv
// Scoreboard bench for waveshaper_softclip with a behavioural divider and
// an arithmetic reference model of the soft-clip curve.
module tb_waveshaper_softclip;

   localparam int KNEE    = 64;
   localparam int DIV_W   = 22;
   localparam int TIMEOUT = 64;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [7:0]       in_sample = 8'd0;
   logic             in_ready;
   logic             div_start;
   logic [DIV_W-1:0] div_dividend;
   logic [DIV_W-1:0] div_divisor;
   logic             div_done = 1'b0;
   logic [7:0]       div_quo = 8'd0;
   logic             out_valid;
   logic [7:0]       out_sample;
   logic             timeout_err;

   int checks = 0;
   int errors = 0;

   logic [7:0]       expQ[$];
   logic [DIV_W-1:0] opDividendQ[$];
   logic [DIV_W-1:0] opDivisorQ[$];
   int               divLat = 0;
   bit               divMute = 1'b0;
   bit               expErr = 1'b0;

   logic [DIV_W-1:0] capDividend, capDivisor, expDividend, expDivisor;
   logic [7:0]       monExp;
   int               lat;

   waveshaper_softclip #(.KNEE(KNEE), .DIV_W(DIV_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample),
      .in_ready(in_ready), .div_start(div_start), .div_dividend(div_dividend),
      .div_divisor(div_divisor), .div_done(div_done), .div_quo(div_quo),
      .out_valid(out_valid), .out_sample(out_sample), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Soft-clip curve from plain integer arithmetic.
   function automatic logic [7:0] refShape(input logic [7:0] x);
      int v, m, q;
      v = int'($signed(x));
      m = (v < 0) ? -v : v;
      if (m == 0) return 8'd0;
      q = (m * (128 + KNEE)) / (m + KNEE);
      if (q > 127) q = 127;
      return (v < 0) ? 8'(-q) : 8'(q);
   endfunction

   function automatic logic [7:0] timeoutRef(input logic [7:0] x);
      return x[7] ? 8'h81 : 8'h7F;
   endfunction

   task automatic applyStimulus(input logic [7:0] x, input int hold, input bit expectTimeout);
      int n, m;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
         return;
      end
      in_valid  = 1'b1;
      in_sample = x;
      expQ.push_back(expectTimeout ? timeoutRef(x) : refShape(x));
      if (x != 8'd0) begin
         m = int'($signed(x));
         if (m < 0) m = -m;
         opDividendQ.push_back(DIV_W'(m * (128 + KNEE)));
         opDivisorQ.push_back(DIV_W'(m + KNEE));
      end
      @(negedge clk);
      for (int i = 0; i < hold; i++) begin
         checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
         in_sample = x + 8'd37;
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((expQ.size() != 0 || !in_ready) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (expQ.size() != 0) begin
         checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
         expQ.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   // Behavioural sequential divider: checks operands, answers after a delay.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && div_start) begin
            capDividend = div_dividend;
            capDivisor  = div_divisor;
            if (opDividendQ.size() == 0) begin
               checkOutput("div_start_unexpected", 32'd1, 32'd0);
            end else begin
               expDividend = opDividendQ.pop_front();
               expDivisor  = opDivisorQ.pop_front();
               checkOutput("div_dividend", 32'(capDividend), 32'(expDividend));
               checkOutput("div_divisor", 32'(capDivisor), 32'(expDivisor));
            end
            @(negedge clk);
            checkOutput("div_start_pulse", 32'(div_start), 32'd0);
            checkOutput("operands_stable", 32'(div_dividend), 32'(capDividend));
            lat = (divLat != 0) ? divLat : int'($urandom_range(1, 8));
            repeat (lat - 1) @(negedge clk);
            if (!divMute) begin
               div_done = 1'b1;
               div_quo  = 8'(capDividend / capDivisor);
               @(negedge clk);
               div_done = 1'b0;
               div_quo  = 8'($urandom);
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the block presents a sample.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("spurious_out_valid", 32'd1, 32'd0);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("out_sample", 32'(out_sample), 32'(monExp));
            checkOutput("timeout_err_at_out", 32'(timeout_err), 32'(expErr));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] x;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_div_start", 32'(div_start), 32'd0);
      checkOutput("rst_dividend", 32'(div_dividend), 32'd0);
      checkOutput("rst_divisor", 32'(div_divisor), 32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_sample", 32'(out_sample), 32'd0);
      checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
      rst = 1'b0;

      // Zero sample bypasses the divider; a stray div_done must be ignored.
      @(negedge clk);
      in_valid  = 1'b1;
      in_sample = 8'd0;
      expQ.push_back(8'd0);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("zero_lat_early", 32'(out_valid), 32'd0);
      checkOutput("zero_no_start", 32'(div_start), 32'd0);
      div_done = 1'b1;
      div_quo  = 8'h55;
      @(negedge clk);
      div_done = 1'b0;
      checkOutput("zero_lat", 32'(out_valid), 32'd1);
      checkOutput("zero_no_start2", 32'(div_start), 32'd0);
      waitDrain();

      divLat = 3;
      applyStimulus(8'd64, 0, 1'b0);
      applyStimulus(8'hC0, 0, 1'b0);
      applyStimulus(8'h80, 0, 1'b0);
      applyStimulus(8'h7F, 0, 1'b0);
      waitDrain();

      // Divider never answers: full-scale clip and sticky error.
      divMute = 1'b1;
      expErr  = 1'b1;
      applyStimulus(8'hD3, 0, 1'b1);
      waitDrain();
      divMute = 1'b0;
      checkOutput("err_sticky", 32'(timeout_err), 32'd1);
      applyStimulus(8'd20, 0, 1'b0);
      waitDrain();
      checkOutput("err_sticky2", 32'(timeout_err), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
      expErr = 1'b0;
      checkOutput("err_cleared", 32'(timeout_err), 32'd0);

      // Reset mid-WAIT, then a late div_done that must be ignored.
      divLat = 20;
      applyStimulus(8'd50, 0, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      expQ.delete();
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_wait_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_wait_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_wait_div_start", 32'(div_start), 32'd0);
      repeat (25) @(negedge clk);
      checkOutput("late_done_in_ready", 32'(in_ready), 32'd1);

      // New sample with in_valid held high while busy.
      divLat = 5;
      applyStimulus(8'd10, 3, 1'b0);
      waitDrain();

      divLat = 0;
      for (int i = 0; i < 40; i++) begin
         x = 8'($urandom);
         if (i % 8 == 0) x = 8'h80;
         if (i % 8 == 4) x = 8'd0;
         applyStimulus(x, 0, 1'b0);
      end
      waitDrain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
